// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: samples rx at mid-bit from a synchronized copy and
// presents each byte on a one-entry valid/ready output register.
module uart_rx_stream #(
  parameter int CYCLES_PER_BIT = 434,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] tdata,
  output logic       tvalid,
  input  logic       tready,
  output logic       overflow,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int H  = CYCLES_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);

  generate
    if (CYCLES_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_rx_stream: CYCLES_PER_BIT must be at least 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_stream: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    tdata_reg, tdata_next;
  logic          tvalid_reg, tvalid_next;
  logic          overflow_reg, overflow_next;
  logic          framing_error_reg, framing_error_next;
  logic          deliver;
  logic          stop_bad;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      bit_idx_reg       <= '0;
      shift_reg         <= '0;
      tdata_reg         <= '0;
      tvalid_reg        <= 1'b0;
      overflow_reg      <= 1'b0;
      framing_error_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      bit_idx_reg       <= bit_idx_next;
      shift_reg         <= shift_next;
      tdata_reg         <= tdata_next;
      tvalid_reg        <= tvalid_next;
      overflow_reg      <= overflow_next;
      framing_error_reg <= framing_error_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    deliver      = 1'b0;
    stop_bad     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Re-check the start bit at its midpoint to reject glitches.
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tdata_next         = tdata_reg;
    tvalid_next        = tvalid_reg;
    overflow_next      = 1'b0;
    framing_error_next = stop_bad;
    if (deliver) begin
      // A same-cycle handshake frees the slot for the new byte.
      if (!tvalid_reg || tready) begin
        tdata_next  = shift_reg;
        tvalid_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end else if (tvalid_reg && tready) begin
      tvalid_next = 1'b0;
    end
  end

  assign tdata         = tdata_reg;
  assign tvalid        = tvalid_reg;
  assign overflow      = overflow_reg;
  assign framing_error = framing_error_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: frame table plus corner-case
// sequences, with handshaked bytes checked against a scoreboard queue.
module tb_uart_rx_stream;

  localparam int CPB  = 4;
  localparam int SYNC = 2;
  localparam int H    = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       overflow;
  logic       framing_error;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_stream #(
    .CYCLES_PER_BIT(CPB),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .tdata        (tdata),
    .tvalid       (tvalid),
    .tready       (tready),
    .overflow     (overflow),
    .framing_error(framing_error),
    .busy         (busy)
  );

  int total    = 0;
  int bad      = 0;
  int hs_count = 0;
  int fe_count = 0;
  int ov_count = 0;

  logic [7:0] sb[$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [7:0] prev_data  = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_fe;
    logic       exp_hs;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame; rst_bit >= 0 pulses reset inside that bit and aborts.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
    logic [9:0] bits;
    logic       aborted;
    bits    = {stop, d, 1'b0};
    aborted = 1'b0;
    $display("send byte=%02h stop=%0b", d, stop);
    for (int i = 0; i < 10 && !aborted; i++) begin
      rx = bits[i];
      for (int c = 0; c < CPB && !aborted; c++) begin
        @(posedge clk);
        #1;
        if (i == rst_bit && c == 1) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst     = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    rx = 1'b1;
  endtask

  // Monitor: samples on the falling edge, between input updates and active edges.
  always @(negedge clk) begin
    logic [7:0] exp_byte;
    if (!rst) begin
      if (framing_error) fe_count++;
      if (overflow) ov_count++;
      if (!prev_rst && prev_valid && !prev_ready) begin
        chk("hold_valid", {31'b0, tvalid}, 32'd1);
        chk("hold_data", {24'b0, tdata}, {24'b0, prev_data});
      end
      if (tvalid && tready) begin
        hs_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %02h expected none", tdata);
        end else begin
          exp_byte = sb.pop_front();
          $display("recv byte=%02h expected=%02h", tdata, exp_byte);
          chk("byte", {24'b0, tdata}, {24'b0, exp_byte});
        end
      end
    end
    prev_valid = tvalid;
    prev_ready = tready;
    prev_data  = tdata;
    prev_rst   = rst;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   exp_hs;
    int   exp_fe;
    int   hs0;
    int   fe0;
    int   ov0;
    logic busy_seen;

    vecs[0] = '{8'hA5, 1'b1, 8, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 8, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b0, 8, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 4, 1'b0, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 8, 1'b0, 1'b1};

    rst    = 1'b1;
    rx     = 1'b1;
    tready = 1'b1;
    idle(3);
    chk("rst_tdata", {24'b0, tdata}, 32'h0);
    chk("rst_tvalid", {31'b0, tvalid}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_framing", {31'b0, framing_error}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    idle(5);

    // Frame table: single bytes, back-to-back bytes and a bad stop bit.
    exp_hs = 0;
    exp_fe = 0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_hs) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, -1);
      idle(vecs[i].gap);
      exp_hs += int'(vecs[i].exp_hs);
      exp_fe += int'(vecs[i].exp_fe);
      if (vecs[i].gap >= 4) begin
        chk($sformatf("vec%0d_hs", i), hs_count, exp_hs);
        chk($sformatf("vec%0d_fe", i), fe_count, exp_fe);
      end
    end
    idle(10);
    chk("table_overflow", ov_count, 0);
    chk("table_sb_empty", sb.size(), 0);

    // Backpressure: second byte overflows, first stays held.
    hs0 = hs_count;
    ov0 = ov_count;
    tready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    idle(4);
    send_frame(8'h22, 1'b1, -1);
    idle(8);
    chk("bp_tvalid", {31'b0, tvalid}, 32'd1);
    chk("bp_tdata", {24'b0, tdata}, 32'h11);
    chk("bp_overflow", ov_count, ov0 + 1);
    tready = 1'b1;
    idle(4);
    chk("bp_drain_tvalid", {31'b0, tvalid}, 32'd0);
    chk("bp_drain_hs", hs_count, hs0 + 1);
    chk("bp_sb_empty", sb.size(), 0);

    // Break: bad stop bit followed by a long low line.
    hs0 = hs_count;
    fe0 = fe_count;
    send_frame(8'h55, 1'b0, -1);
    rx = 1'b0;
    idle(40);
    chk("brk_busy", {31'b0, busy}, 32'd1);
    chk("brk_fe", fe_count, fe0 + 1);
    chk("brk_tvalid", {31'b0, tvalid}, 32'd0);
    rx = 1'b1;
    idle(8);
    chk("brk_release_busy", {31'b0, busy}, 32'd0);
    sb.push_back(8'h66);
    send_frame(8'h66, 1'b1, -1);
    idle(8);
    chk("brk_next_hs", hs_count, hs0 + 1);
    chk("brk_fe_total", fe_count, fe0 + 1);

    // One-cycle glitch while idle must be rejected as a false start.
    hs0 = hs_count;
    fe0 = fe_count;
    busy_seen = 1'b0;
    rx = 1'b0;
    for (int k = 0; k < H + SYNC + 2; k++) begin
      @(posedge clk);
      #1;
      rx = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    chk("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
    chk("glitch_busy_done", {31'b0, busy}, 32'd0);
    idle(10);
    chk("glitch_hs", hs_count, hs0);
    chk("glitch_fe", fe_count, fe0);
    chk("glitch_tvalid", {31'b0, tvalid}, 32'd0);

    // Reset during data bit 4 aborts the frame.
    hs0 = hs_count;
    send_frame(8'h99, 1'b1, 5);
    chk("mid_rst_tdata", {24'b0, tdata}, 32'h0);
    chk("mid_rst_tvalid", {31'b0, tvalid}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_overflow", {31'b0, overflow}, 32'h0);
    chk("mid_rst_framing", {31'b0, framing_error}, 32'h0);
    idle(12);
    chk("mid_rst_no_byte", hs_count, hs0);
    sb.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1);
    idle(8);
    chk("post_rst_hs", hs_count, hs0 + 1);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_fe", fe_count, fe0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Serial UART receiver: converts an 8N1 asynchronous bit stream on `rx` into bytes on a valid/ready byte-stream output.
- It is the receiving counterpart of the team's UART transmitter.
- It is the DUT exercised by VUnit SystemVerilog test suites: the UART verification component drives `rx`, and the bench consumes the byte stream.

Parameters:
- CYCLES_PER_BIT, default 434: `clk` cycles per UART bit. Legal range ≥ 4; elaboration fails below 4.
- SYNC_STAGES, default 2: number of flip-flops in the `rx` synchronizer. Legal range ≥ 2.

Ports:
- clk  input  1  system clock. Every flop is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial input. Idle level is 1.
- tdata  output  8  received byte, LSB = first data bit on the line.
- tvalid  output  1  `tdata` holds an unconsumed byte.
- tready  input  1  consumer accepts `tdata` when `tvalid` and `tready` are both 1.
- overflow  output  1  one-cycle pulse: a completed byte was dropped because the output register was occupied.
- framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
- busy  output  1  1 whenever the state machine is not in IDLE.

Behaviour:
- Reset (`rst` = 1 at a rising `clk` edge):
  - All synchronizer stages load 1.
  - State goes to IDLE; bit counter and cycle counter clear.
  - Outputs: `tdata` = 0, `tvalid` = 0, `overflow` = 0, `framing_error` = 0, `busy` = 0.
  - Reset mid-frame or mid-handshake aborts the frame and discards any pending byte.
- Synchronizer: `rx_s` is `rx` delayed by SYNC_STAGES cycles. All decisions use `rx_s` only.
- Cycle counter width is `$clog2(CYCLES_PER_BIT)`. Half-bit point H = CYCLES_PER_BIT/2, rounded down.
- State machine:
  - IDLE: when `rx_s` = 0, go to START and clear the cycle counter.
  - START: count to H-1, then sample.
    - `rx_s` = 0: go to DATA, clear the counter, bit index = 0.
    - `rx_s` = 1: false start; return to IDLE with no output.
  - DATA: every CYCLES_PER_BIT cycles, sample `rx_s` into shift[bit index].
    - Bits are received LSB first.
    - After bit index 7 is sampled, go to STOP.
  - STOP: after CYCLES_PER_BIT cycles, sample `rx_s`.
    - `rx_s` = 1: deliver the byte (see output register), then go to IDLE. IDLE can detect a new start bit on the very next cycle.
    - `rx_s` = 0: pulse `framing_error` for 1 cycle, discard the byte, go to BREAK.
  - BREAK: stay until `rx_s` = 1, then go to IDLE. A held-low line (break) produces exactly one `framing_error`.
- Latency: the byte is delivered on the cycle of the stop-bit sample, i.e. SYNC_STAGES + H + 9·CYCLES_PER_BIT cycles after the falling edge of the start bit reaches `rx` (±1 cycle of input-sampling uncertainty). `tvalid` rises one cycle later.
- Output register (one entry):
  - Deliver with `tvalid` = 0: load `tdata`; `tvalid` goes to 1 next cycle.
  - Deliver with `tvalid` = 1 and `tready` = 1 in the same cycle: the handshake completes, the new byte loads, and `tvalid` stays 1. There is no overflow.
  - Deliver with `tvalid` = 1 and `tready` = 0: pulse `overflow` for 1 cycle, drop the new byte, keep the old `tdata` unchanged.
  - `tdata` is stable while `tvalid` = 1 and `tready` = 0.
  - `tvalid` falls on the cycle after `tvalid` and `tready` are both 1, unless a delivery happens in that same cycle.
- Error flags: `framing_error` and `overflow` are never sticky. Both are registered outputs.
- `busy` = 1 in START, DATA, STOP and BREAK.

Test Plan:
All scenarios use CYCLES_PER_BIT = 4, SYNC_STAGES = 2, `tready` = 1 unless stated.
1. Send 0xA5 as 8N1 -> exactly one handshake with `tdata` = 0xA5; `overflow` = 0 and `framing_error` = 0 throughout.
2. Send 0x00, 0xFF, 0x3C back-to-back with one stop bit each and no idle gap -> handshakes carry 0x00, 0xFF, 0x3C in order.
3. Hold `tready` = 0 and send 0x11 then 0x22 -> `tvalid` = 1 with `tdata` = 0x11; one `overflow` pulse at the 0x22 stop sample. Then raise `tready` -> a single handshake of 0x11, after which `tvalid` = 0.
4. Send 0x55 with stop bit = 0, then hold `rx` low for 40 cycles -> one `framing_error` pulse and no `tvalid`. Release `rx`, then send 0x66 -> `tdata` = 0x66.
5. Apply a 1-cycle low glitch on `rx` while idle -> no output, no error flag, and `busy` returns to 0 within H + SYNC_STAGES + 2 cycles.
6. Assert `rst` for 1 cycle during data bit 4 of 0x99 -> outputs are at reset values on the next cycle and no byte is delivered. A following 0x42 is received correctly.
